// File: rtl/pocket_pkg.sv
// Shared types and constants for the pocket detector: hole ids, event record and FSM states.
package pocket_pkg;

    localparam logic [2:0] HOLE_NONE = 3'd0;
    localparam int NUM_HOLES = 6;
    // Event records carry the index width of the default 16-ball table.
    localparam int BALL_IDX_W = 4;

    typedef logic [2:0] hole_id_t;

    typedef struct packed {
        logic [BALL_IDX_W-1:0] ball;
        hole_id_t              hole;
    } pocket_event_t;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } evt_state_t;

endpackage

// File: rtl/overlap_counter.sv
// Per-ball overlap counter: saturates at the threshold, flags the frame hit and
// latches the hole seen on the threshold-crossing pixel.
module overlap_counter
    import pocket_pkg::*;
#(
    parameter int THRESHOLD = 24,
    parameter int CNT_W     = 6
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     clear,
    input  logic     hit,
    input  hole_id_t hole_number,
    output logic     frame_hit,
    output hole_id_t hit_hole
);

    logic [CNT_W-1:0] cnt;

    // Once frame_hit is set the counter stops, which is how it saturates at THRESHOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            frame_hit <= 1'b0;
            hit_hole  <= HOLE_NONE;
        end else if (clear) begin
            cnt       <= '0;
            frame_hit <= 1'b0;
        end else if (hit && !frame_hit) begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(THRESHOLD - 1)) begin
                frame_hit <= 1'b1;
                hit_hole  <= hole_number;
            end
        end
    end

endmodule

// File: rtl/pocket_detector.sv
// Counts ball/hole overlap per frame and reports each pocketed ball once as a ball/hole event.
// Optional macro POCKET_EVENT_COUNT_EN adds pocketCount, a saturating count of accepted events.
module pocket_detector
    import pocket_pkg::*;
#(
    parameter int NUM_BALLS         = 16,
    parameter int OVERLAP_THRESHOLD = 24,
    parameter int CNT_W             = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         startOfFrame,
    input  logic                         drawingRequestHoles,
    input  logic [2:0]                   holeNumber,
    input  logic [NUM_BALLS-1:0]         ballDrawingRequest,
    input  logic                         clearPocketed,
    output logic                         eventValid,
    output logic [$clog2(NUM_BALLS)-1:0] eventBall,
    output logic [2:0]                   eventHole,
    input  logic                         eventReady,
    output logic [NUM_BALLS-1:0]         pocketedMask
`ifdef POCKET_EVENT_COUNT_EN
    ,
    output logic [4:0]                   pocketCount
`endif
);

    localparam int BALL_W = $clog2(NUM_BALLS);

    logic hole_valid;
    logic frame_clear;
    logic commit;

    logic [NUM_BALLS-1:0] frame_hit;
    logic [NUM_BALLS-1:0] pending;
    logic [NUM_BALLS-1:0] pocketed;
    logic [NUM_BALLS-1:0] accept_mask;
    hole_id_t             hit_hole           [NUM_BALLS];
    hole_id_t             hit_hole_committed [NUM_BALLS];

    evt_state_t    state, state_next;
    pocket_event_t evt_q;
    logic          load, accept;
    logic [BALL_W-1:0] lowest;

    assign hole_valid  = drawingRequestHoles && (holeNumber != HOLE_NONE);
    assign frame_clear = clearPocketed || startOfFrame;
    assign commit      = startOfFrame && !clearPocketed;

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
        overlap_counter #(
            .THRESHOLD (OVERLAP_THRESHOLD),
            .CNT_W     (CNT_W)
        ) u_cnt (
            .clk         (clk),
            .reset       (reset),
            .clear       (frame_clear),
            .hit         (hole_valid && ballDrawingRequest[g] && !pocketed[g]),
            .hole_number (holeNumber),
            .frame_hit   (frame_hit[g]),
            .hit_hole    (hit_hole[g])
        );
    end

    always_comb begin
        lowest = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            if (pending[i]) lowest = BALL_W'(i);
        end
    end

    // Handshake: eventValid rises only from IDLE and then holds eventBall/eventHole
    // unchanged until a cycle with eventValid && eventReady, which is the transfer.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (pending != '0) begin
                    load       = 1'b1;
                    state_next = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (eventReady) begin
                    accept     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (clearPocketed) begin
            load       = 1'b0;
            accept     = 1'b0;
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    assign accept_mask = accept ? (NUM_BALLS'(1) << evt_q.ball[BALL_W-1:0]) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            pocketed <= '0;
            evt_q    <= '0;
        end else if (clearPocketed) begin
            pending  <= '0;
            pocketed <= '0;
        end else begin
            pending <= (pending & ~accept_mask) | (commit ? frame_hit : '0);
            if (commit) pocketed <= pocketed | frame_hit;
            if (load) begin
                evt_q.ball <= BALL_IDX_W'(lowest);
                evt_q.hole <= hit_hole_committed[lowest];
            end
        end
    end

    // Snapshot the hole only for newly hit balls so pending entries stay intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_BALLS; i++) hit_hole_committed[i] <= HOLE_NONE;
        end else if (commit) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (frame_hit[i]) hit_hole_committed[i] <= hit_hole[i];
            end
        end
    end

`ifdef POCKET_EVENT_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset || clearPocketed) pocketCount <= '0;
        else if (accept && pocketCount != 5'd31) pocketCount <= pocketCount + 5'd1;
    end
`endif

    assign eventValid   = (state == S_PRESENT);
    assign eventBall    = evt_q.ball[BALL_W-1:0];
    assign eventHole    = evt_q.hole;
    assign pocketedMask = pocketed;

endmodule

// File: tb/tb_pocket_detector.sv
// Directed bench for pocket_detector: a frame-level reference model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_pocket_detector;

    localparam int NB = 16;
    localparam int TH = 24;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          startOfFrame;
    logic          drawingRequestHoles;
    logic [2:0]    holeNumber;
    logic [NB-1:0] ballDrawingRequest;
    logic          clearPocketed;
    logic          eventValid;
    logic [3:0]    eventBall;
    logic [2:0]    eventHole;
    logic          eventReady;
    logic [NB-1:0] pocketedMask;
`ifdef POCKET_EVENT_COUNT_EN
    logic [4:0]    pocketCount;
`endif

    pocket_detector #(
        .NUM_BALLS         (NB),
        .OVERLAP_THRESHOLD (TH),
        .CNT_W             (6)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .startOfFrame        (startOfFrame),
        .drawingRequestHoles (drawingRequestHoles),
        .holeNumber          (holeNumber),
        .ballDrawingRequest  (ballDrawingRequest),
        .clearPocketed       (clearPocketed),
        .eventValid          (eventValid),
        .eventBall           (eventBall),
        .eventHole           (eventHole),
        .eventReady          (eventReady),
        .pocketedMask        (pocketedMask)
`ifdef POCKET_EVENT_COUNT_EN
        ,
        .pocketCount         (pocketCount)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks overlap per ball in plain integers; events are issued lowest ball first.
    int            m_cnt   [NB];
    int            m_hole  [NB];
    int            m_chole [NB];
    logic [NB-1:0] m_fhit, m_pend, m_mask, old_pend;
    logic          m_valid;
    int            m_ball, m_ehole, m_count, pick;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NB; i++) begin
                m_cnt[i] = 0; m_hole[i] = 0; m_chole[i] = 0;
            end
            m_fhit = '0; m_pend = '0; m_mask = '0;
            m_valid = 1'b0; m_ball = 0; m_ehole = 0; m_count = 0;
        end else if (clearPocketed) begin
            for (int i = 0; i < NB; i++) m_cnt[i] = 0;
            m_fhit = '0; m_pend = '0; m_mask = '0;
            m_valid = 1'b0; m_count = 0;
        end else begin
            old_pend = m_pend;
            if (startOfFrame) begin
                for (int i = 0; i < NB; i++) begin
                    if (m_fhit[i]) begin
                        m_pend[i] = 1'b1; m_mask[i] = 1'b1; m_chole[i] = m_hole[i];
                    end
                    m_cnt[i] = 0;
                end
                m_fhit = '0;
            end else begin
                for (int i = 0; i < NB; i++) begin
                    if (drawingRequestHoles && holeNumber != 3'd0 && ballDrawingRequest[i]
                        && !m_mask[i] && !m_fhit[i]) begin
                        m_cnt[i]++;
                        if (m_cnt[i] == TH) begin
                            m_fhit[i] = 1'b1;
                            m_hole[i] = int'(holeNumber);
                        end
                    end
                end
            end
            if (m_valid) begin
                if (eventReady) begin
                    m_pend[m_ball] = 1'b0;
                    m_valid = 1'b0;
                    if (m_count < 31) m_count++;
                end
            end else if (old_pend != '0) begin
                pick = 0;
                for (int i = NB - 1; i >= 0; i--) if (old_pend[i]) pick = i;
                m_ball = pick; m_ehole = m_chole[pick]; m_valid = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            check("cyc_valid", 32'(eventValid), 32'(m_valid));
            if (m_valid) begin
                check("cyc_ball", 32'(eventBall), 32'(m_ball));
                check("cyc_hole", 32'(eventHole), 32'(m_ehole));
            end
            check("cyc_mask", 32'(pocketedMask), 32'(m_mask));
`ifdef POCKET_EVENT_COUNT_EN
            check("cyc_count", 32'(pocketCount), 32'(m_count));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pix(input logic [NB-1:0] balls, input logic [2:0] hole, input int n,
                       input logic dreq);
        drawingRequestHoles = dreq;
        holeNumber          = hole;
        ballDrawingRequest  = balls;
        cyc(n);
        drawingRequestHoles = 1'b0;
        holeNumber          = 3'd0;
        ballDrawingRequest  = '0;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        cyc(1);
        startOfFrame = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1'b1; startOfFrame = 1'b0; drawingRequestHoles = 1'b0; holeNumber = 3'd0;
        ballDrawingRequest = '0; clearPocketed = 1'b0; eventReady = 1'b0;
        @(negedge clk);
        cyc(3);
        check("rst_valid", 32'(eventValid), 32'd0);
        check("rst_ball",  32'(eventBall),  32'd0);
        check("rst_hole",  32'(eventHole),  32'd0);
        check("rst_mask",  32'(pocketedMask), 32'd0);
        reset = 1'b0;
        cyc(2);

        // Ball 3 on hole 2 for 30 pixels: one event, one cycle after commit.
        eventReady = 1'b1;
        pix(16'h0008, 3'd2, 30, 1'b1);
        cyc(1);
        sof();
        check("t1_latency", 32'(eventValid), 32'd0);
        cyc(1);
        check("t1_valid", 32'(eventValid), 32'd1);
        check("t1_ball",  32'(eventBall),  32'd3);
        check("t1_hole",  32'(eventHole),  32'd2);
        check("t1_mask",  32'(pocketedMask), 32'h0008);
        cyc(1);
        check("t1_done", 32'(eventValid), 32'd0);

        // Ball 5 one pixel short in two consecutive frames.
        pix(16'h0020, 3'd4, 23, 1'b1);
        sof();
        cyc(3);
        pix(16'h0020, 3'd4, 23, 1'b1);
        sof();
        cyc(4);
        check("t2_valid", 32'(eventValid), 32'd0);
        check("t2_mask",  32'(pocketedMask), 32'h0008);

        // Overlap sums across holes; the crossing pixel's hole is reported.
        pix(16'h0200, 3'd3, 10, 1'b1);
        pix(16'h0200, 3'd5, 14, 1'b1);
        sof();
        cyc(1);
        check("attr_ball", 32'(eventBall), 32'd9);
        check("attr_hole", 32'(eventHole), 32'd5);
        cyc(2);

        // Balls 7 and 1 in one frame; ready held low for 5 cycles.
        eventReady = 1'b0;
        pix(16'h0080, 3'd6, 24, 1'b1);
        pix(16'h0002, 3'd1, 24, 1'b1);
        sof();
        cyc(1);
        for (int k = 0; k < 5; k++) begin
            check("t3_hold_ball", 32'(eventBall), 32'd1);
            check("t3_hold_hole", 32'(eventHole), 32'd1);
            cyc(1);
        end
        eventReady = 1'b1;
        cyc(1);
        check("t3_gap", 32'(eventValid), 32'd0);
        cyc(1);
        check("t3_second_valid", 32'(eventValid), 32'd1);
        check("t3_second_ball",  32'(eventBall),  32'd7);
        check("t3_second_hole",  32'(eventHole),  32'd6);
        cyc(2);
        check("t3_mask", 32'(pocketedMask), 32'h028A);

        // Already pocketed ball 3 crossing hole 5 does nothing.
        pix(16'h0008, 3'd5, 40, 1'b1);
        sof();
        cyc(4);
        check("t4_valid", 32'(eventValid), 32'd0);
        check("t4_mask",  32'(pocketedMask), 32'h028A);

        // Pixel coinciding with startOfFrame is discarded (23 + 1 stays below threshold).
        pix(16'h0040, 3'd2, 23, 1'b1);
        drawingRequestHoles = 1'b1; holeNumber = 3'd2; ballDrawingRequest = 16'h0040;
        sof();
        drawingRequestHoles = 1'b0; holeNumber = 3'd0; ballDrawingRequest = '0;
        cyc(1);
        sof();
        cyc(3);
        check("sof_pixel_mask", 32'(pocketedMask), 32'h028A);

        // Ball 2 presented, then withdrawn by clearPocketed.
        eventReady = 1'b0;
        pix(16'h0004, 3'd3, 24, 1'b1);
        sof();
        cyc(1);
        check("t5_valid", 32'(eventValid), 32'd1);
        check("t5_ball",  32'(eventBall),  32'd2);
`ifdef POCKET_EVENT_COUNT_EN
        check("t5_count_before", 32'(pocketCount), 32'd4);
`endif
        clearPocketed = 1'b1;
        cyc(1);
        clearPocketed = 1'b0;
        check("t5_withdrawn", 32'(eventValid), 32'd0);
        check("t5_mask",      32'(pocketedMask), 32'd0);
`ifdef POCKET_EVENT_COUNT_EN
        check("t5_count", 32'(pocketCount), 32'd0);
`endif
        cyc(3);
        check("t5_stay_idle", 32'(eventValid), 32'd0);

        // Hole request with hole number 0 is ignored.
        eventReady = 1'b1;
        pix(16'h0001, 3'd0, 50, 1'b1);
        sof();
        cyc(4);
        check("t6_valid", 32'(eventValid), 32'd0);
        check("t6_mask",  32'(pocketedMask), 32'd0);

        // Reset in the middle of a presented event.
        eventReady = 1'b0;
        pix(16'h0010, 3'd6, 24, 1'b1);
        sof();
        cyc(1);
        check("t7_valid", 32'(eventValid), 32'd1);
        check("t7_ball",  32'(eventBall),  32'd4);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("t7_rst_valid", 32'(eventValid), 32'd0);
        check("t7_rst_ball",  32'(eventBall),  32'd0);
        check("t7_rst_hole",  32'(eventHole),  32'd0);
        check("t7_rst_mask",  32'(pocketedMask), 32'd0);
        cyc(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pocket_detector.md
Name: pocket_detector

Overview:
- Downstream consumer of the hole renderer. Each frame it watches the per-pixel hole request and hole number alongside the per-ball draw requests.
- Counts the overlap pixels between each ball and any hole. A ball whose overlap reaches a threshold is declared pocketed.
- Each pocketing is reported once to the game controller as a ball/hole event over a valid/ready handshake.

Parameters:
- NUM_BALLS, 16, number of ball draw-request lines (ball index 0..NUM_BALLS-1).
- OVERLAP_THRESHOLD, 24, overlap pixels in one frame required to pocket a ball; must be >= 1 and < 2**CNT_W.
- CNT_W, 6, width of each per-ball overlap counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at frame start.
- drawingRequestHoles  in  1  a hole pixel is being drawn at this cycle.
- holeNumber  in  3  hole id 1..6; 0 means no hole.
- ballDrawingRequest  in  NUM_BALLS  bit i set when ball i draws at this pixel; pixel-aligned with the hole inputs.
- clearPocketed  in  1  one-cycle pulse at new-game start; clears sticky pocketed state.
- eventValid  out  1  pocket event available.
- eventBall  out  $clog2(NUM_BALLS)  ball index of the event.
- eventHole  out  3  hole id 1..6 of the event.
- eventReady  in  1  consumer accepts the event.
- pocketedMask  out  NUM_BALLS  sticky set of pocketed balls.

Behaviour:
- Reset: all counters 0, hitHole[] 0, frameHit 0, pending 0, pocketedMask 0, eventValid 0, eventBall 0, eventHole 0.
- Hole-valid qualifier: drawingRequestHoles && holeNumber != 0. A pixel with drawingRequestHoles=1 but holeNumber=0 is ignored.
- Accumulate phase, each cycle, for each ball i:
  - If qualifier && ballDrawingRequest[i] && !pocketedMask[i] && !frameHit[i], cnt[i] increments.
  - cnt[i] saturates at OVERLAP_THRESHOLD.
  - The cycle cnt[i] reaches OVERLAP_THRESHOLD: set frameHit[i] and latch hitHole[i]=holeNumber. Later pixels in the same frame do not change hitHole[i].
- Hole attribution: counts are not per hole. Overlap with different holes sums, and the hole active on the threshold-crossing pixel is the one reported.
- Frame commit, on the cycle startOfFrame=1:
  - pending |= frameHit; pocketedMask |= frameHit.
  - frameHit and all cnt[] clear.
  - Pixel hits in this same cycle are discarded; a new frame has no visible pixel on its first cycle.
- Event FSM, states IDLE and PRESENT:
  - IDLE: if pending != 0, select the lowest set index k. Register eventBall=k and eventHole=hitHoleCommitted[k], assert eventValid, go to PRESENT. This gives 1 cycle of latency from commit to eventValid.
  - PRESENT: outputs are held stable while eventReady=0. On eventValid && eventReady, clear pending[k], deassert eventValid the next cycle, go to IDLE.
  - Back-to-back events therefore issue at most one every 2 cycles.
- hitHoleCommitted[]: a copy of hitHole[] taken at commit, so the next frame's accumulation cannot corrupt a pending event.
- Commit during PRESENT: new bits OR into pending. The presented event is unaffected. No event is lost, because each ball can pocket at most once per game.
- Coincidences:
  - startOfFrame and accept in the same cycle: both take effect. The accepted bit clears and new bits set; a bit cannot be both, because of the sticky mask.
  - clearPocketed: pocketedMask, pending, frameHit and cnt[] all clear. An event in PRESENT is withdrawn: eventValid goes to 0 next cycle and the FSM returns to IDLE.
  - clearPocketed has priority over startOfFrame in the same cycle.
- Reset mid-operation: identical to clearPocketed plus the output reset values. Reset has priority over everything.

Optional Feature:
- Macro: POCKET_EVENT_COUNT_EN.
- When defined:
  - Adds output pocketCount [4:0], the count of accepted events, saturating at 31.
  - Cleared by reset or clearPocketed.
  - Increments on the accept cycle and is visible the next cycle.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package pocket_pkg:
  - HOLE_NONE = 3'd0.
  - NUM_HOLES = 6.
  - typedef hole_id_t (logic [2:0]).
  - typedef pocket_event_t struct {ball, hole}.
- Sub-module overlap_counter: one instance per ball, generate loop. Contains the saturating counter, frameHit and the hitHole latch, with inputs hit, clear and holeNumber.

Test Plan:
- Ball 3 overlaps hole 2 for 30 pixels, then startOfFrame, eventReady=1 → eventValid high 1 cycle after commit with eventBall=3, eventHole=2; pocketedMask[3]=1.
- Ball 5 overlaps hole 4 for only 23 pixels, then startOfFrame → no event; cnt cleared; next frame's 23 pixels also produce no event.
- Balls 7 and 1 both cross the threshold in one frame, holes 6 and 1, with eventReady held 0 for 5 cycles then 1 → ball 1/hole 1 is held stable for all 5 cycles, then ball 7/hole 6 follows 2 cycles later.
- Pocketed ball 3 overlaps hole 5 for 40 pixels in the next frame → no new event; pocketedMask unchanged.
- eventValid asserted for ball 2, then clearPocketed pulsed → eventValid=0 next cycle; pocketedMask=0; with the macro defined, pocketCount=0.
- drawingRequestHoles=1 with holeNumber=0 and ballDrawingRequest[0]=1 for 50 pixels → no count and no event.
